// File: rtl/adder_chk_pkg.sv
// Shared definitions for the adder result checker and later adder benches:
// session state encoding, default operand width and fail_vec field layout.
package adder_chk_pkg;

  localparam int DEF_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // fail_vec is packed as {a, b, cin, sum, cout}; these give each field's LSB
  localparam int FV_COUT_POS = 0;
  localparam int FV_SUM_LSB  = 1;

  function automatic int fv_cin_pos(input int w);
    return w + 1;
  endfunction

  function automatic int fv_b_lsb(input int w);
    return w + 2;
  endfunction

  function automatic int fv_a_lsb(input int w);
    return 2 * w + 2;
  endfunction

  function automatic int fv_width(input int w);
    return 3 * w + 2;
  endfunction

endpackage

// File: rtl/adder_result_checker_if.sv
// Sample bus between the adder under test and its checker: the operands fed
// to the adder, the adder's answer and a valid strobe marking a sample.
interface adder_result_checker_if
  import adder_chk_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) ();

  logic             valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (output valid, a, b, cin, sum, cout);
  modport slave  (input  valid, a, b, cin, sum, cout);

endinterface

// File: rtl/adder_golden.sv
// Combinational reference adder: {exp_cout, exp_sum} = a + b + cin evaluated
// at WIDTH+1 bits so the carry out is exact.
module adder_golden
  import adder_chk_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] exp_sum,
  output logic             exp_cout
);

  assign {exp_cout, exp_sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

endmodule

// File: rtl/adder_result_checker.sv
// Session-based checker for a WIDTH-bit adder. Each accepted sample is
// registered with its match bit (stage 1); one cycle later the pass/fail
// statistics update (stage 2). The session ends after NUM_VEC samples, with
// done rising on the same edge as the last statistic update.
module adder_result_checker
  import adder_chk_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int CNT_W   = 8,
  parameter int NUM_VEC = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  adder_result_checker_if.slave bus,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     pass_cnt,
  output logic [CNT_W-1:0]     fail_cnt,
  output logic                 err_flag,
  output logic [3*WIDTH+1:0]   fail_vec
);

  localparam int               VEC_W     = fv_width(WIDTH);
  localparam logic [CNT_W-1:0] NUM_VEC_C = CNT_W'(NUM_VEC);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t             state;
  logic [CNT_W-1:0]   acc_cnt;
  logic               s1_vld;
  logic               s1_match;
  logic [VEC_W-1:0]   s1_vec;
  logic [WIDTH-1:0]   exp_sum;
  logic               exp_cout;
  logic               match;
  logic               accept;

  adder_golden #(.WIDTH(WIDTH)) u_golden (
    .a        (bus.a),
    .b        (bus.b),
    .cin      (bus.cin),
    .exp_sum  (exp_sum),
    .exp_cout (exp_cout)
  );

  // Case equality so an unknown sum/cout can never be scored as a match.
  assign match  = (bus.sum === exp_sum) && (bus.cout === exp_cout);
  // Samples count only while running, never alongside start, and stop once
  // the session quota has been taken.
  assign accept = (state == RUN) && bus.valid && !start && (acc_cnt != NUM_VEC_C);

  // Session FSM, sample stage and statistics stage with registered outputs.
  always_ff @(posedge clk) begin
    // NOTE: every register here, including the pipeline stage, is cleared by
    // the synchronous reset so an aborted session leaves no pending update.
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      acc_cnt  <= '0;
      s1_vld   <= 1'b0;
      s1_match <= 1'b0;
      s1_vec   <= '0;
      pass_cnt <= '0;
      fail_cnt <= '0;
      err_flag <= 1'b0;
      fail_vec <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so stage 2 reads the
      // stage-1 values from before this edge and the default below is
      // overridden only by a later assignment in the same block.
      s1_vld <= 1'b0;
      if (start) begin
        // start from any state (re)opens a session and drops a pending update
        state    <= RUN;
        busy     <= 1'b1;
        done     <= 1'b0;
        acc_cnt  <= '0;
        pass_cnt <= '0;
        fail_cnt <= '0;
        err_flag <= 1'b0;
        fail_vec <= '0;
      end else begin
        if (accept) begin
          s1_vld   <= 1'b1;
          s1_match <= match;
          s1_vec   <= {bus.a, bus.b, bus.cin, bus.sum, bus.cout};
          acc_cnt  <= acc_cnt + CNT_ONE;
        end
        if (s1_vld) begin
          if (s1_match) begin
            if (pass_cnt != '1) pass_cnt <= pass_cnt + CNT_ONE;
          end else begin
            if (fail_cnt != '1) fail_cnt <= fail_cnt + CNT_ONE;
            if (!err_flag) begin
              err_flag <= 1'b1;
              fail_vec <= s1_vec;
            end
          end
        end
        // Quota reached on the previous edge: the last update lands now.
        if (state == RUN && acc_cnt == NUM_VEC_C) begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_adder_result_checker.sv
// Bench for adder_result_checker: a scoreboard of expected statistics is
// pushed as each sample is accepted and popped one edge later, when the
// checker's counters should reflect it. A second instance with 2-bit
// counters exercises the saturating counter width.
module tb_adder_result_checker;
  import adder_chk_pkg::*;

  localparam int NV  = 4;
  localparam int NV2 = 3;

  typedef struct {
    int          pass;
    int          fail;
    bit          err;
    logic [13:0] vec;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        start2;
  logic        busy, done, err_flag;
  logic [7:0]  pass_cnt, fail_cnt;
  logic [13:0] fail_vec;
  logic        busy2, done2, err2;
  logic [1:0]  pass2, fail2;
  logic [13:0] vec2;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb_q[$];

  // reference model of the main instance's session
  bit          m_run;
  int          m_acc, m_pass, m_fail;
  bit          m_err;
  logic [13:0] m_vec;

  adder_result_checker_if #(.WIDTH(4)) bus  ();
  adder_result_checker_if #(.WIDTH(4)) bus2 ();

  adder_result_checker #(.WIDTH(4), .CNT_W(8), .NUM_VEC(NV)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bus(bus),
    .busy(busy), .done(done), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
    .err_flag(err_flag), .fail_vec(fail_vec)
  );

  adder_result_checker #(.WIDTH(4), .CNT_W(2), .NUM_VEC(NV2)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start2), .bus(bus2),
    .busy(busy2), .done(done2), .pass_cnt(pass2), .fail_cnt(fail2),
    .err_flag(err2), .fail_vec(vec2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // One clock; compare the oldest pending expectation after the edge.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check("sb_pass_cnt", pass_cnt, e.pass);
      check("sb_fail_cnt", fail_cnt, e.fail);
      check("sb_err_flag", err_flag, e.err);
      check("sb_fail_vec", fail_vec, e.vec);
    end
  endtask

  task automatic idle(input int n);
    bus.valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic cin,
                       input logic [3:0] sum, input logic cout);
    bus.a = a; bus.b = b; bus.cin = cin; bus.sum = sum; bus.cout = cout;
  endtask

  task automatic send(input logic [3:0] a, input logic [3:0] b, input logic cin,
                      input logic [3:0] sum, input logic cout);
    logic [4:0] t;
    bit         ok;
    bit         acc;
    exp_t       e;
    drive(a, b, cin, sum, cout);
    bus.valid = 1'b1;
    t   = {1'b0, a} + {1'b0, b} + {4'b0, cin};
    ok  = (t == {cout, sum});
    acc = m_run && (m_acc < NV);
    tick();
    if (acc) begin
      m_acc++;
      if (ok) m_pass++;
      else begin
        m_fail++;
        if (!m_err) begin
          m_err = 1'b1;
          m_vec = {a, b, cin, sum, cout};
        end
      end
      if (m_acc == NV) m_run = 1'b0;
      e.pass = m_pass; e.fail = m_fail; e.err = m_err; e.vec = m_vec;
      sb_q.push_back(e);
    end
    bus.valid = 1'b0;
  endtask

  task automatic do_start();
    sb_q.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
    m_run = 1'b1; m_acc = 0; m_pass = 0; m_fail = 0; m_err = 1'b0; m_vec = '0;
  endtask

  task automatic send2_bad();
    bus2.a = 4'd1; bus2.b = 4'd1; bus2.cin = 1'b0; bus2.sum = 4'd0; bus2.cout = 1'b0;
    bus2.valid = 1'b1;
    tick();
    bus2.valid = 1'b0;
  endtask

  initial begin
    logic [3:0] fa;
    rst_n = 1'b0; start = 1'b0; start2 = 1'b0;
    m_run = 1'b0; m_acc = 0; m_pass = 0; m_fail = 0; m_err = 1'b0; m_vec = '0;
    bus.valid = 1'b0; drive(4'd0, 4'd0, 1'b0, 4'd0, 1'b0);
    bus2.valid = 1'b0; bus2.a = '0; bus2.b = '0; bus2.cin = 1'b0; bus2.sum = '0; bus2.cout = 1'b0;

    // reset and idle behaviour
    tick(); tick();
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_pass", pass_cnt, 8'd0);
    check("rst_fail", fail_cnt, 8'd0);
    check("rst_err", err_flag, 1'b0);
    check("rst_vec", fail_vec, 14'd0);
    check("rst_sat_fail", fail2, 2'd0);
    rst_n = 1'b1;
    send(4'd3, 4'd5, 1'b1, 4'd0, 1'b1);
    send(4'd7, 4'd2, 1'b0, 4'd1, 1'b0);
    send(4'd9, 4'd9, 1'b1, 4'd4, 1'b0);
    check("idle_busy", busy, 1'b0);
    check("idle_pass", pass_cnt, 8'd0);
    check("idle_fail", fail_cnt, 8'd0);

    // clean session
    do_start();
    check("clean_busy", busy, 1'b1);
    check("clean_done0", done, 1'b0);
    send(4'd0, 4'd0, 1'b0, 4'd0, 1'b0);
    send(4'd8, 4'd1, 1'b0, 4'd9, 1'b0);
    send(4'd15, 4'd1, 1'b0, 4'd0, 1'b1);
    send(4'd4, 4'd4, 1'b1, 4'd9, 1'b0);
    check("clean_not_early", done, 1'b0);
    tick();
    check("clean_done", done, 1'b1);
    check("clean_busy_off", busy, 1'b0);
    check("clean_pass", pass_cnt, 8'd4);
    check("clean_fail", fail_cnt, 8'd0);
    check("clean_err", err_flag, 1'b0);

    // first-mismatch capture
    do_start();
    check("mm_cleared", pass_cnt, 8'd0);
    send(4'd8, 4'd8, 1'b1, 4'd0, 1'b1);
    send(4'd1, 4'd2, 1'b0, 4'd3, 1'b0);
    send(4'd3, 4'd3, 1'b0, 4'd7, 1'b0);
    send(4'd0, 4'd0, 1'b0, 4'd0, 1'b0);
    tick();
    check("mm_fail", fail_cnt, 8'd2);
    check("mm_pass", pass_cnt, 8'd2);
    check("mm_err", err_flag, 1'b1);
    check("mm_vec", fail_vec, 14'b1000_1000_1_0000_1);
    fa = fail_vec[fv_a_lsb(4) +: 4];
    check("mm_vec_a", fa, 4'd8);
    check("mm_vec_cin", fail_vec[fv_cin_pos(4)], 1'b1);
    check("mm_vec_cout", fail_vec[FV_COUT_POS], 1'b1);
    check("mm_done", done, 1'b1);

    // gapped valid
    do_start();
    send(4'd1, 4'd1, 1'b0, 4'd2, 1'b0);
    idle(2);
    send(4'd2, 4'd2, 1'b0, 4'd4, 1'b0);
    idle(1);
    send(4'd7, 4'd7, 1'b1, 4'd15, 1'b0);
    idle(3);
    check("gap_busy", busy, 1'b1);
    check("gap_done0", done, 1'b0);
    check("gap_pass3", pass_cnt, 8'd3);
    send(4'd9, 4'd9, 1'b0, 4'd2, 1'b1);
    tick();
    check("gap_done", done, 1'b1);
    check("gap_pass", pass_cnt, 8'd4);
    send(4'd1, 4'd1, 1'b1, 4'd0, 1'b0);
    tick();
    check("post_done_pass", pass_cnt, 8'd4);
    check("post_done_fail", fail_cnt, 8'd0);

    // restart mid-session, with valid asserted alongside start
    do_start();
    send(4'd5, 4'd5, 1'b0, 4'd10, 1'b0);
    send(4'd6, 4'd1, 1'b1, 4'd8, 1'b0);
    drive(4'd3, 4'd3, 1'b0, 4'd0, 1'b0);
    bus.valid = 1'b1;
    do_start();
    bus.valid = 1'b0;
    check("rs_pass0", pass_cnt, 8'd0);
    check("rs_busy", busy, 1'b1);
    idle(1);
    check("rs_no_stale", pass_cnt, 8'd0);
    check("rs_no_start_sample", fail_cnt, 8'd0);
    send(4'd1, 4'd0, 1'b0, 4'd1, 1'b0);
    send(4'd2, 4'd0, 1'b0, 4'd2, 1'b0);
    send(4'd3, 4'd0, 1'b0, 4'd3, 1'b0);
    tick();
    check("rs_not_early", done, 1'b0);
    send(4'd4, 4'd0, 1'b0, 4'd4, 1'b0);
    tick();
    check("rs_done", done, 1'b1);
    check("rs_pass", pass_cnt, 8'd4);

    // reset mid-session drops the pending update
    do_start();
    send(4'd1, 4'd1, 1'b0, 4'd2, 1'b0);
    send(4'd2, 4'd2, 1'b0, 4'd0, 1'b0);
    rst_n = 1'b0;
    sb_q.delete();
    m_run = 1'b0;
    tick();
    check("mr_busy", busy, 1'b0);
    check("mr_pass", pass_cnt, 8'd0);
    check("mr_fail", fail_cnt, 8'd0);
    rst_n = 1'b1;
    tick();
    check("mr_stale_fail", fail_cnt, 8'd0);
    check("mr_err", err_flag, 1'b0);
    check("mr_done", done, 1'b0);
    send(4'd1, 4'd1, 1'b0, 4'd2, 1'b0);
    tick();
    check("mr_idle_pass", pass_cnt, 8'd0);

    // 2-bit counters: all-fail sessions around a restart
    start2 = 1'b1; tick(); start2 = 1'b0;
    send2_bad(); send2_bad(); send2_bad();
    tick();
    check("sat_fail", fail2, 2'd3);
    check("sat_pass", pass2, 2'd0);
    check("sat_done", done2, 1'b1);
    check("sat_err", err2, 1'b1);
    check("sat_vec", vec2, 14'b0001_0001_0_0000_0);
    start2 = 1'b1; tick(); start2 = 1'b0;
    check("sat_rs_fail", fail2, 2'd0);
    check("sat_rs_busy", busy2, 1'b1);
    send2_bad(); send2_bad(); send2_bad();
    tick();
    tick();
    check("sat_fail_again", fail2, 2'd3);
    check("sat_done_again", done2, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
